// File: rtl/shift_seq_32b_pkg.sv
// Shared types, constants and helpers for the multi-cycle logical shift sequencer.
package shift_seq_32b_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  localparam int   SHAMT_W   = 5;

  // Lowest set bit of amt at or above position from (0 when none).
  function automatic logic [2:0] next_set_bit(input logic [SHAMT_W-1:0] amt,
                                               input logic [2:0] from);
    logic [2:0] r;
    r = 3'd0;
    for (int i = SHAMT_W - 1; i >= 0; i--) begin
      if (amt[i] && (3'(i) >= from)) begin
        r = 3'(i);
      end
    end
    return r;
  endfunction

  function automatic logic [2:0] highest_set_bit(input logic [SHAMT_W-1:0] amt);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < SHAMT_W; i++) begin
      if (amt[i]) begin
        r = 3'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_stage_32b.sv
// One power-of-two shift stage: shifts A by 2^K (K = 0..4) left or right, zero fill.
module shift_stage_32b
  import shift_seq_32b_pkg::*;
(
  output logic [31:0] O,
  input  logic [31:0] A,
  input  logic [2:0]  K,
  input  logic        D
);

  logic [SHAMT_W-1:0] sh_s;

  // Decode the stage index into a shift distance and apply it in the requested direction.
  always_comb begin
    case (K)
      3'd0:    sh_s = 5'd1;
      3'd1:    sh_s = 5'd2;
      3'd2:    sh_s = 5'd4;
      3'd3:    sh_s = 5'd8;
      3'd4:    sh_s = 5'd16;
      default: sh_s = 5'd0;
    endcase
    if (D == DIR_RIGHT) begin
      O = A >> sh_s;
    end else begin
      O = A << sh_s;
    end
  end

endmodule

// File: rtl/shift_seq_32b.sv
// Multi-cycle logical shifter: walks one 2^k stage per clock over B[4:0] and
// holds the result until acknowledged.
module shift_seq_32b
  import shift_seq_32b_pkg::*;
#(
  parameter int unsigned ZERO_SKIP = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        D,
  input  logic        ack,
  output logic        busy,
  output logic        done,
  output logic [31:0] O
);

  state_e             state_q, state_d;
  logic [31:0]        acc_q, acc_d;
  logic [SHAMT_W-1:0] amt_q, amt_d;
  logic [2:0]         idx_q, idx_d;
  logic               dir_q, dir_d;
  logic               big_q, big_d;
  logic [31:0]        o_q, o_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [31:0]        stage_o_s;
  logic [31:0]        acc_nxt_s;
  logic [2:0]         last_idx_s;
  logic               skip_s;

  shift_stage_32b u_stage (
    .O (stage_o_s),
    .A (acc_q),
    .K (idx_q),
    .D (dir_q)
  );

  assign skip_s = (ZERO_SKIP != 0);

  // Next-state, datapath and output-register computation.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    amt_d      = amt_q;
    idx_d      = idx_q;
    dir_d      = dir_q;
    big_d      = big_q;
    o_d        = o_q;
    last_idx_s = skip_s ? highest_set_bit(amt_q) : 3'd4;
    // big_q never reaches RUN; the guard keeps a corrupted entry from leaking data.
    if (big_q) begin
      acc_nxt_s = 32'd0;
    end else if (amt_q[idx_q]) begin
      acc_nxt_s = stage_o_s;
    end else begin
      acc_nxt_s = acc_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d = A;
          amt_d = B[SHAMT_W-1:0];
          dir_d = D;
          big_d = |B[31:SHAMT_W];
          if (|B[31:SHAMT_W]) begin
            o_d     = 32'd0;
            state_d = ST_DONE;
          end else if (skip_s && (B[SHAMT_W-1:0] == 5'd0)) begin
            o_d     = A;
            state_d = ST_DONE;
          end else begin
            idx_d   = skip_s ? next_set_bit(B[SHAMT_W-1:0], 3'd0) : 3'd0;
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_d = acc_nxt_s;
        if (idx_q == last_idx_s) begin
          o_d     = acc_nxt_s;
          state_d = ST_DONE;
        end else begin
          idx_d = skip_s ? next_set_bit(amt_q, idx_q + 3'd1) : (idx_q + 3'd1);
        end
      end
      ST_DONE: begin
        if (ack) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State, datapath and output registers; reset drops any in-flight request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      acc_q   <= 32'd0;
      amt_q   <= 5'd0;
      idx_q   <= 3'd0;
      dir_q   <= DIR_LEFT;
      big_q   <= 1'b0;
      o_q     <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      amt_q   <= amt_d;
      idx_q   <= idx_d;
      dir_q   <= dir_d;
      big_q   <= big_d;
      o_q     <= o_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign O    = o_q;

endmodule

// File: tb/tb_shift_seq_32b.sv
// Self-checking bench: two instances (ZERO_SKIP = 0 and 1), directed table,
// corner sequences and random requests against an arithmetic reference model.
module tb_shift_seq_32b;

  logic        clk;
  logic        reset;
  logic        start_s [2];
  logic [31:0] a_s     [2];
  logic [31:0] b_s     [2];
  logic        d_s     [2];
  logic        ack_s   [2];
  logic        busy_s  [2];
  logic        done_s  [2];
  logic [31:0] o_s     [2];

  int n_checks;
  int n_fail;

  shift_seq_32b #(.ZERO_SKIP(0)) dut0 (
    .clk(clk), .reset(reset), .start(start_s[0]), .A(a_s[0]), .B(b_s[0]), .D(d_s[0]),
    .ack(ack_s[0]), .busy(busy_s[0]), .done(done_s[0]), .O(o_s[0])
  );

  shift_seq_32b #(.ZERO_SKIP(1)) dut1 (
    .clk(clk), .reset(reset), .start(start_s[1]), .A(a_s[1]), .B(b_s[1]), .D(d_s[1]),
    .ack(ack_s[1]), .busy(busy_s[1]), .done(done_s[1]), .O(o_s[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          z;
    logic [31:0] a;
    logic [31:0] b;
    logic        d;
    logic [31:0] exp_o;
    int          exp_lat;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_o(input logic [31:0] a, input logic [31:0] b,
                                          input logic d);
    int amt;
    amt = int'(b[4:0]);
    if (b[31:5] != 27'd0) return 32'd0;
    if (d) return a >> amt;
    return a << amt;
  endfunction

  function automatic int model_lat(input int z, input logic [31:0] b);
    int pc;
    if (b[31:5] != 27'd0) return 1;
    if (z == 0) return 6;
    pc = $countones(b[4:0]);
    return 1 + pc;
  endfunction

  // Issue one request, measure capture-to-done latency, read O, then ack.
  task automatic run_req(input int z, input logic [31:0] a, input logic [31:0] b,
                         input logic d, output logic [31:0] o, output int lat);
    @(negedge clk);
    start_s[z] = 1'b1;
    a_s[z] = a;
    b_s[z] = b;
    d_s[z] = d;
    @(posedge clk);
    #1;
    start_s[z] = 1'b0;
    a_s[z] = $urandom;
    b_s[z] = $urandom;
    d_s[z] = 1'($urandom_range(0, 1));
    check("busy_after_capture", 32'(busy_s[z]), 32'd1);
    lat = 1;
    while (!done_s[z] && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    o = o_s[z];
    @(negedge clk);
    ack_s[z] = 1'b1;
    @(posedge clk);
    #1;
    ack_s[z] = 1'b0;
    check("busy_after_ack", 32'(busy_s[z]), 32'd0);
  endtask

  logic [31:0] got_o;
  int          got_lat;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0;
      ack_s[i]   = 1'b0;
      a_s[i]     = 32'd0;
      b_s[i]     = 32'd0;
      d_s[i]     = 1'b0;
    end

    tbl[0]  = '{0, 32'h0000_0001, 32'd31,        1'b0, 32'h8000_0000, 6};
    tbl[1]  = '{1, 32'h0000_0001, 32'd31,        1'b0, 32'h8000_0000, 6};
    tbl[2]  = '{1, 32'h8000_0000, 32'd4,         1'b1, 32'h0800_0000, 2};
    tbl[3]  = '{0, 32'hFFFF_FFFF, 32'h0000_0020, 1'b0, 32'h0000_0000, 1};
    tbl[4]  = '{1, 32'hFFFF_FFFF, 32'h0000_0020, 1'b0, 32'h0000_0000, 1};
    tbl[5]  = '{1, 32'h1234_5678, 32'd0,         1'b0, 32'h1234_5678, 1};
    tbl[6]  = '{0, 32'h1234_5678, 32'd0,         1'b0, 32'h1234_5678, 6};
    tbl[7]  = '{0, 32'h8000_0000, 32'd4,         1'b1, 32'h0800_0000, 6};
    tbl[8]  = '{1, 32'h0000_00FF, 32'd10,        1'b0, 32'h0003_FC00, 3};
    tbl[9]  = '{1, 32'hA5A5_A5A5, 32'h8000_0001, 1'b1, 32'h0000_0000, 1};
    tbl[10] = '{0, 32'hF000_000F, 32'd17,        1'b1, 32'h0000_7800, 6};
    tbl[11] = '{1, 32'hF000_000F, 32'd17,        1'b1, 32'h0000_7800, 3};

    reset = 1'b1;
    #12;
    for (int i = 0; i < 2; i++) begin
      check("reset_busy", 32'(busy_s[i]), 32'd0);
      check("reset_done", 32'(done_s[i]), 32'd0);
      check("reset_o", o_s[i], 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_req(tbl[i].z, tbl[i].a, tbl[i].b, tbl[i].d, got_o, got_lat);
      check($sformatf("tbl%0d_o", i), got_o, tbl[i].exp_o);
      check($sformatf("tbl%0d_lat", i), 32'(got_lat), 32'(tbl[i].exp_lat));
    end

    // start held through RUN and DONE, then start together with ack
    @(negedge clk);
    start_s[0] = 1'b1;
    a_s[0] = 32'h0000_0001;
    b_s[0] = 32'd3;
    d_s[0] = 1'b0;
    @(posedge clk);
    #1;
    a_s[0] = 32'hDEAD_BEEF;
    b_s[0] = 32'd0;
    got_lat = 1;
    while (!done_s[0] && got_lat < 20) begin
      @(posedge clk);
      #1;
      got_lat++;
    end
    check("hold_lat", 32'(got_lat), 32'd6);
    check("hold_o", o_s[0], 32'h0000_0008);
    repeat (2) @(posedge clk);
    #1;
    check("hold_done_stays", 32'(done_s[0]), 32'd1);
    check("hold_o_stays", o_s[0], 32'h0000_0008);
    @(negedge clk);
    ack_s[0] = 1'b1;
    @(posedge clk);
    #1;
    check("ackstart_busy", 32'(busy_s[0]), 32'd0);
    check("ackstart_done", 32'(done_s[0]), 32'd0);
    check("ackstart_o", o_s[0], 32'h0000_0008);
    @(negedge clk);
    ack_s[0] = 1'b0;
    start_s[0] = 1'b0;
    @(posedge clk);
    #1;
    check("ackstart_no_capture", 32'(busy_s[0]), 32'd0);

    // asynchronous reset in the third RUN cycle
    @(negedge clk);
    start_s[0] = 1'b1;
    a_s[0] = 32'h0000_0001;
    b_s[0] = 32'd31;
    d_s[0] = 1'b0;
    @(posedge clk);
    #1;
    start_s[0] = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("midrun_reset_busy", 32'(busy_s[0]), 32'd0);
    check("midrun_reset_done", 32'(done_s[0]), 32'd0);
    check("midrun_reset_o", o_s[0], 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_req(0, 32'h0000_00F0, 32'd4, 1'b1, got_o, got_lat);
    check("post_reset_o", got_o, 32'h0000_000F);
    check("post_reset_lat", 32'(got_lat), 32'd6);

    // random requests against the arithmetic model
    for (int i = 0; i < 60; i++) begin
      int          z;
      logic [31:0] a;
      logic [31:0] b;
      logic        d;
      z = int'($urandom_range(0, 1));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 31));
      d = 1'($urandom_range(0, 1));
      run_req(z, a, b, d, got_o, got_lat);
      check($sformatf("rand%0d_o", i), got_o, model_o(a, b, d));
      check($sformatf("rand%0d_lat", i), 32'(got_lat), 32'(model_lat(z, b)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
